nfu_3_pipe: RTL

- NFU-3 activation stage.
- Consumes the Tn partial-sum lanes produced by the NFU-2 adder-tree stage, once a neuron's accumulation is complete.
- Applies a piecewise-linear activation y = a[seg]*x + b[seg] to each lane in parallel, using a software-loaded coefficient table.
- Fully pipelined with a valid/ready handshake; feeds NBout writeback.

---
 rtl/nfu_pkg.sv | 18 +
 rtl/nfu_3_lane.sv | 65 ++++++
 rtl/nfu_3_pipe.sv | 79 +++++++
 3 files changed

// File: rtl/nfu_pkg.sv
// nfu_pkg: shared widths, saturation bounds and coefficient entry for the NFU stages
package nfu_pkg;
    localparam int BIT_WIDTH = 16;
    localparam int FRAC_BITS = 8;
    localparam int TN        = 16;

    function automatic int SEG_IDX_W(input int n);
        return $clog2(n);
    endfunction

    localparam logic signed [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic signed [BIT_WIDTH-1:0] a;
        logic signed [BIT_WIDTH-1:0] b;
    } coef_t;
endpackage

// File: rtl/nfu_3_lane.sv
// nfu_3_lane: one lane of the NFU-3 activation, segment lookup -> multiply -> shift/add/saturate
// Ports: clk, rst (sync, active-high), adv (pipeline advance), tbl (shared coefficient table),
//        x (lane input), y (registered activated output). With NFU3_BYPASS_EN, byp selects x at S3.
module nfu_3_lane
    import nfu_pkg::*;
#(
    parameter int NUM_SEG = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv,
    input  coef_t [NUM_SEG-1:0]         tbl,
    input  logic signed [BIT_WIDTH-1:0] x,
`ifdef NFU3_BYPASS_EN
    input  logic                        byp,
`endif
    output logic signed [BIT_WIDTH-1:0] y
);
    localparam int SW = SEG_IDX_W(NUM_SEG);
    localparam logic [SW-1:0] MID = SW'(NUM_SEG / 2);
    localparam logic signed [2*BIT_WIDTH-1:0] HI = SAT_MAX;
    localparam logic signed [2*BIT_WIDTH-1:0] LO = SAT_MIN;

    logic [SW-1:0]                 seg;
    logic signed [BIT_WIDTH-1:0]   x1, a1, b1, b2, sat, y_n;
    logic signed [2*BIT_WIDTH-1:0] p2, sum;
`ifdef NFU3_BYPASS_EN
    logic signed [BIT_WIDTH-1:0]   x2;
`endif

    // The table spans the full input range, so the clamp is implicit: the segment is the
    // top SW bits of x offset by NUM_SEG/2, and adding NUM_SEG/2 mod NUM_SEG flips the MSB.
    assign seg = x[BIT_WIDTH-1 -: SW] ^ MID;
    assign sum = (p2 >>> FRAC_BITS) + b2;
    assign sat = sum > HI ? SAT_MAX : sum < LO ? SAT_MIN : sum[BIT_WIDTH-1:0];
`ifdef NFU3_BYPASS_EN
    assign y_n = byp ? x2 : sat;
`else
    assign y_n = sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x1 <= '0;
            a1 <= '0;
            b1 <= '0;
            p2 <= '0;
            b2 <= '0;
            y  <= '0;
`ifdef NFU3_BYPASS_EN
            x2 <= '0;
`endif
        end else if (adv) begin
            x1 <= x;
            a1 <= tbl[seg].a;
            b1 <= tbl[seg].b;
            p2 <= a1 * x1;
            b2 <= b1;
            y  <= y_n;
`ifdef NFU3_BYPASS_EN
            x2 <= x1;
`endif
        end
    end
endmodule

// File: rtl/nfu_3_pipe.sv
// nfu_3_pipe: NFU-3 piecewise-linear activation stage, Tn lanes, 3-cycle valid/ready pipeline
// Ports: clk, rst (sync, active-high); i_valid/o_ready/i_data input handshake;
//        o_valid/i_ready/o_data output handshake; i_cfg_we/i_cfg_addr/i_cfg_a/i_cfg_b table write.
// Lane width and fraction bits come from nfu_pkg.
// Optional macro NFU3_BYPASS_EN adds i_bypass: a bypassed vector leaves unchanged.
module nfu_3_pipe
    import nfu_pkg::*;
#(
    parameter int Tn      = TN,
    parameter int NUM_SEG = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [Tn*BIT_WIDTH-1:0]          i_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [Tn*BIT_WIDTH-1:0]          o_data,
    input  logic                             i_cfg_we,
    input  logic [SEG_IDX_W(NUM_SEG)-1:0]    i_cfg_addr,
    input  logic [BIT_WIDTH-1:0]             i_cfg_a,
    input  logic [BIT_WIDTH-1:0]             i_cfg_b
`ifdef NFU3_BYPASS_EN
    ,
    input  logic                             i_bypass
`endif
);
    localparam coef_t IDENT = '{a: BIT_WIDTH'(1 << FRAC_BITS), b: '0};

    logic                 adv, v1, v2;
    coef_t [NUM_SEG-1:0]  tbl;
`ifdef NFU3_BYPASS_EN
    logic                 b1, b2;
`endif

    // One global enable: the whole pipe moves whenever the output slot is free or draining.
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_valid <= 1'b0;
            tbl     <= {NUM_SEG{IDENT}};
`ifdef NFU3_BYPASS_EN
            b1      <= 1'b0;
            b2      <= 1'b0;
`endif
        end else begin
            // Table writes ignore stalls; S1 reads the pre-write entry in the same cycle.
            if (i_cfg_we) tbl[i_cfg_addr] <= '{a: i_cfg_a, b: i_cfg_b};
            if (adv) begin
                v1      <= i_valid;
                v2      <= v1;
                o_valid <= v2;
`ifdef NFU3_BYPASS_EN
                b1      <= i_bypass;
                b2      <= b1;
`endif
            end
        end
    end

    for (genvar k = 0; k < Tn; k++) begin : g_lane
        nfu_3_lane #(.NUM_SEG(NUM_SEG)) u_lane (
            .clk (clk),
            .rst (rst),
            .adv (adv),
            .tbl (tbl),
            .x   (i_data[k*BIT_WIDTH +: BIT_WIDTH]),
`ifdef NFU3_BYPASS_EN
            .byp (b2),
`endif
            .y   (o_data[k*BIT_WIDTH +: BIT_WIDTH])
        );
    end
endmodule
